// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron argmax block.
// FSM encoding and signed saturation bounds.
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int VAL_W = 26;

  // Saturation bounds for a signed value of width w.
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  localparam logic signed [VAL_W-1:0] VAL_MAX = VAL_W'(sat_max(VAL_W));
  localparam logic signed [VAL_W-1:0] VAL_MIN = VAL_W'(sat_min(VAL_W));

endpackage

// File: rtl/neuron_argmax_if.sv
// Beat input and result output bundle of neuron_argmax.
// in_bias exists only with NEURON_ARGMAX_BIAS_EN defined.
interface neuron_argmax_if #(
  parameter int VAL_SIZE = 26,
  parameter int IDX_W    = 4
);
  logic                       in_valid;
  logic                       in_ready;
  logic signed [VAL_SIZE-1:0] in_value;
  logic                       in_last;
`ifdef NEURON_ARGMAX_BIAS_EN
  logic signed [VAL_SIZE-1:0] in_bias;
`endif
  logic                       out_valid;
  logic                       out_ready;
  logic [IDX_W-1:0]           out_class;
  logic signed [VAL_SIZE-1:0] out_score;
  logic                       out_error;

  modport slave (
`ifdef NEURON_ARGMAX_BIAS_EN
    input  in_bias,
`endif
    input  in_valid, in_value, in_last, out_ready,
    output in_ready, out_valid, out_class, out_score,
    output out_error
  );

  modport master (
`ifdef NEURON_ARGMAX_BIAS_EN
    output in_bias,
`endif
    output in_valid, in_value, in_last, out_ready,
    input  in_ready, out_valid, out_class, out_score,
    input  out_error
  );
endinterface

// File: rtl/sat_add.sv
// Signed adder saturating to the W-bit two's-complement range.
// Used only when NEURON_ARGMAX_BIAS_EN is defined.
module sat_add
  import neuron_pkg::*;
#(
  parameter int W = 26
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] sum_o
);
  localparam logic signed [W-1:0] MAX = W'(sat_max(W));
  localparam logic signed [W-1:0] MIN = W'(sat_min(W));

  logic signed [W:0] sum;

  // One extra bit holds the exact sum; top two bits differ on overflow.
  always_comb begin
    sum   = {a_i[W-1], a_i} + {b_i[W-1], b_i};
    sum_o = sum[W-1:0];
    if (sum[W] != sum[W-1]) begin
      sum_o = sum[W] ? MIN : MAX;
    end
  end
endmodule

// File: rtl/neuron_argmax.sv
// Streaming argmax over NEURON_N signed neuron values per frame.
// Optional bias add with saturation: NEURON_ARGMAX_BIAS_EN.
module neuron_argmax
  import neuron_pkg::*;
#(
  parameter int VAL_SIZE = 26,
  parameter int NEURON_N = 10,
  parameter int IDX_W    = 4
) (
  input logic           clk,
  input logic           GlobalReset,
  neuron_argmax_if.slave bus
);
  localparam logic [IDX_W-1:0] CNT_END = IDX_W'(NEURON_N - 1);

  state_e                     state_q;
  logic [IDX_W-1:0]           cnt_q;
  logic [IDX_W-1:0]           idx_q;
  logic signed [VAL_SIZE-1:0] best_q;
  logic                       vld_q;
  logic [IDX_W-1:0]           cls_q;
  logic signed [VAL_SIZE-1:0] score_q;
  logic                       err_q;

  logic signed [VAL_SIZE-1:0] val;
  logic signed [VAL_SIZE-1:0] best_d;
  logic [IDX_W-1:0]           idx_d;
  logic                       beat;
  logic                       take;
  logic                       at_end;
  logic                       term;

`ifdef NEURON_ARGMAX_BIAS_EN
  sat_add #(
    .W(VAL_SIZE)
  ) u_sat (
    .a_i  (bus.in_value),
    .b_i  (bus.in_bias),
    .sum_o(val)
  );
`else
  assign val = bus.in_value;
`endif

  assign bus.in_ready  = (state_q != HOLD);
  assign bus.out_valid = vld_q;
  assign bus.out_class = cls_q;
  assign bus.out_score = score_q;
  assign bus.out_error = err_q;

  // First beat always wins; later beats only on strictly greater.
  always_comb begin
    beat   = bus.in_valid && bus.in_ready;
    take   = (state_q == IDLE) || (val > best_q);
    best_d = take ? val : best_q;
    idx_d  = take ? cnt_q : idx_q;
    at_end = (cnt_q == CNT_END);
    term   = bus.in_last || at_end;
  end

  // Frame FSM with registered result outputs.
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      best_q  <= '0;
      vld_q   <= 1'b0;
      cls_q   <= '0;
      score_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, ACCUM: begin
          if (beat) begin
            best_q <= best_d;
            idx_q  <= idx_d;
            if (term) begin
              state_q <= HOLD;
              vld_q   <= 1'b1;
              cls_q   <= idx_d;
              score_q <= best_d;
              err_q   <= !(bus.in_last && at_end);
            end else begin
              state_q <= ACCUM;
              cnt_q   <= cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (vld_q && bus.out_ready) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_argmax.sv
// Bench for neuron_argmax: frame-level argmax model, directed
// pinning cases, then randomized traffic with random backpressure.
module tb_neuron_argmax;
  localparam int VS = 26;
  localparam int NN = 10;
  localparam int IW = 4;
  localparam longint VMAX = (64'sd1 <<< (VS - 1)) - 1;
  localparam longint VMIN = -(64'sd1 <<< (VS - 1));

  logic clk = 1'b0;
  logic GlobalReset = 1'b1;
  always #5 clk = ~clk;

  neuron_argmax_if #(.VAL_SIZE(VS), .IDX_W(IW)) bus();

  neuron_argmax #(
    .VAL_SIZE(VS),
    .NEURON_N(NN),
    .IDX_W   (IW)
  ) dut (
    .clk        (clk),
    .GlobalReset(GlobalReset),
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;
  longint cur_bias = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint clampv(input longint v);
    if (v > VMAX) return VMAX;
    if (v < VMIN) return VMIN;
    return v;
  endfunction

  // Frame-level model: collect accepted values, decide at frame end.
  longint q[$];
  bit     exp_v = 1'b0;
  longint exp_cls, exp_sc;
  bit     exp_err;

  always @(negedge clk) begin : model
    longint v, mx;
    if (GlobalReset) begin
      q.delete();
      exp_v = 1'b0;
    end else begin
      chk("out_valid", longint'(bus.out_valid), longint'(exp_v));
      chk("in_ready", longint'(bus.in_ready), longint'(!exp_v));
      if (exp_v) begin
        chk("out_class", longint'(bus.out_class), exp_cls);
        chk("out_score", longint'(bus.out_score), exp_sc);
        chk("out_error", longint'(bus.out_error), longint'(exp_err));
        if (bus.out_ready) exp_v = 1'b0;
      end else if (bus.in_valid) begin
        v = longint'(bus.in_value);
`ifdef NEURON_ARGMAX_BIAS_EN
        v = clampv(v + longint'(bus.in_bias));
`endif
        q.push_back(v);
        if (bus.in_last || q.size() == NN) begin
          mx = q[0];
          foreach (q[i]) if (q[i] > mx) mx = q[i];
          exp_cls = -1;
          foreach (q[i]) if (exp_cls < 0 && q[i] == mx) exp_cls = i;
          exp_sc  = mx;
          exp_err = !(bus.in_last && q.size() == NN);
          exp_v   = 1'b1;
          q.delete();
        end
      end
    end
  end

  task automatic beat(input logic signed [VS-1:0] v, input bit l);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_value = v;
    bus.in_last  = l;
`ifdef NEURON_ARGMAX_BIAS_EN
    bus.in_bias = VS'(cur_bias);
`endif
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) chk("beat_timeout", 0, 1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic expect_res(input string nm, input longint cls,
                            input longint sc, input bit er);
    @(negedge clk);
    chk({nm, "_valid"}, longint'(bus.out_valid), 1);
    chk({nm, "_class"}, longint'(bus.out_class), cls);
    chk({nm, "_score"}, longint'(bus.out_score), sc);
    chk({nm, "_error"}, longint'(bus.out_error), longint'(er));
    @(posedge clk);
    #1;
  endtask

  int a34[NN] = '{5, -3, 9, 9, 2, 0, 1, -7, 8, 4};
  int a38[NN] = '{1, 2, 3, 4, 99, 5, 6, 7, 8, 9};

  initial begin
    int tmp;
    logic signed [VS-1:0] rv;
    bus.in_valid  = 1'b0;
    bus.in_value  = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
`ifdef NEURON_ARGMAX_BIAS_EN
    bus.in_bias = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", longint'(bus.out_valid), 0);
    chk("rst_class", longint'(bus.out_class), 0);
    chk("rst_score", longint'(bus.out_score), 0);
    chk("rst_error", longint'(bus.out_error), 0);
    chk("rst_ready", longint'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    GlobalReset = 1'b0;

    bus.out_ready = 1'b1;
    for (int i = 0; i < NN; i++) beat(VS'(a34[i]), i == NN - 1);
    expect_res("mixed", 2, 9, 1'b0);

    for (int i = 0; i < NN; i++) beat(-VS'(100), i == NN - 1);
    expect_res("ties", 0, -100, 1'b0);

    beat(VS'(1), 1'b0);
    beat(VS'(7), 1'b0);
    beat(VS'(3), 1'b1);
    expect_res("short", 1, 7, 1'b1);

    bus.out_ready = 1'b0;
    for (int i = 0; i < NN; i++) beat(VS'(i * 3 - 10), 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", longint'(bus.out_valid), 1);
      chk("hold_class", longint'(bus.out_class), 9);
      chk("hold_score", longint'(bus.out_score), 17);
      chk("hold_error", longint'(bus.out_error), 1);
      chk("hold_ready", longint'(bus.in_ready), 0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("hs_valid", longint'(bus.out_valid), 1);
    chk("hs_ready", longint'(bus.in_ready), 0);
    @(negedge clk);
    chk("post_valid", longint'(bus.out_valid), 0);
    chk("post_ready", longint'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) beat(VS'(50 + 10 * i), 1'b0);
    GlobalReset = 1'b1;
    @(negedge clk);
    chk("midrst_valid", longint'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    GlobalReset = 1'b0;
    for (int i = 0; i < NN; i++) beat(VS'(a38[i]), i == NN - 1);
    expect_res("after_rst", 4, 99, 1'b0);

`ifdef NEURON_ARGMAX_BIAS_EN
    cur_bias = 10;
    beat(VS'(VMAX), 1'b1);
    expect_res("sat_hi", 0, VMAX, 1'b1);
    cur_bias = -1;
    beat(VS'(VMIN), 1'b1);
    expect_res("sat_lo", 0, VMIN, 1'b1);
    cur_bias = 0;
`endif

    repeat (1500) begin
      case ($urandom % 3)
        0: rv = VS'($urandom);
        1: begin
          tmp = int'($urandom_range(0, 7)) - 4;
          rv  = VS'(tmp);
        end
        default: rv = ($urandom % 2) ? VS'(VMAX) : VS'(VMIN);
      endcase
      bus.in_valid  = ($urandom % 4) != 0;
      bus.in_value  = rv;
      bus.in_last   = ($urandom % 8) == 0;
      bus.out_ready = ($urandom % 2) == 0;
`ifdef NEURON_ARGMAX_BIAS_EN
      tmp = int'($urandom_range(0, 7)) - 4;
      bus.in_bias = ($urandom % 4 == 0) ? VS'($urandom) : VS'(tmp);
`endif
      @(posedge clk);
      #1;
    end

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/neuron_argmax.md
NEURON_ARGMAX -- requirements
Module: neuron_argmax

Interface
REQ-001 Parameter VAL_SIZE, default 26: width of a signed two's-complement dot-product value.
REQ-002 Parameter NEURON_N, default 10: number of neuron values per classification frame.
REQ-003 Parameter IDX_W, default 4: width of the class index; SHALL satisfy 2^IDX_W >= NEURON_N.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 GlobalReset  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  in_value is valid this cycle.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_value  input  VAL_SIZE  signed neuron dot-product value.
REQ-009 in_last  input  1  marks the final beat of a frame.
REQ-010 in_bias  input  VAL_SIZE  signed per-neuron bias; present only when NEURON_ARGMAX_BIAS_EN is defined.
REQ-011 out_valid  output  1  a frame result is held.
REQ-012 out_ready  input  1  downstream takes the result.
REQ-013 out_class  output  IDX_W  index of the winning neuron.
REQ-014 out_score  output  VAL_SIZE  value of the winning neuron.
REQ-015 out_error  output  1  frame length differed from NEURON_N.

Function
REQ-016 The block SHALL use a three-state FSM: IDLE (no beat yet), ACCUM (at least one beat), HOLD (result presented).
REQ-017 A beat SHALL transfer when in_valid and in_ready are both high; in_ready SHALL be high in IDLE and ACCUM and low in HOLD.
REQ-018 Each transferred beat SHALL take the index equal to the frame beat count (first beat = 0) and SHALL then increment the count.
REQ-019 The first beat of a frame SHALL unconditionally load the best score and best index.
REQ-020 Any later beat SHALL replace the best only when its value is strictly greater in signed order; ties SHALL keep the lower index.
REQ-021 IDLE SHALL go to ACCUM on a beat without in_last.
REQ-022 IDLE or ACCUM SHALL go to HOLD on a beat with in_last, or on the beat whose index is NEURON_N-1, whichever comes first.
REQ-023 out_valid, out_class, out_score and out_error SHALL be registered and visible the cycle after the terminating beat (latency 1).
REQ-024 out_error SHALL be 1 if the frame ended on in_last with fewer than NEURON_N beats, or reached NEURON_N beats with in_last low; otherwise it SHALL be 0.
REQ-025 In HOLD, all outputs SHALL be stable until out_valid and out_ready are both high; the FSM SHALL then enter IDLE, clear the beat count, and drop out_valid on the next cycle.
REQ-026 in_ready SHALL rise in the cycle after the output handshake, never in the same cycle; there is no combinational path from out_ready to in_ready.
REQ-027 out_ready asserted while out_valid is low SHALL have no effect.

Reset
REQ-028 On GlobalReset: state=IDLE, beat count=0, best score=0, best index=0, out_valid=0, out_class=0, out_score=0, out_error=0; in_ready SHALL be 1 after reset release.
REQ-029 Reset asserted mid-frame or in HOLD SHALL discard the partial frame or pending result; no result is emitted.

Configuration
REQ-030 With NEURON_ARGMAX_BIAS_EN defined, the compared value SHALL be in_value+in_bias, computed at VAL_SIZE+1 bits and saturated to the signed VAL_SIZE range; out_score SHALL be this biased value.
REQ-031 Without NEURON_ARGMAX_BIAS_EN, the in_bias port SHALL be absent and in_value SHALL be compared directly.

Structure
REQ-032 A shared package neuron_pkg SHALL hold the FSM state encoding (IDLE/ACCUM/HOLD) and the VAL_SIZE saturation bounds.
REQ-033 A sub-module sat_add (signed saturating adder, VAL_SIZE parameter) SHALL be instantiated only under NEURON_ARGMAX_BIAS_EN.

Verification
REQ-034 Values 5,-3,9,9,2,0,1,-7,8,last=4 (10 beats, in_last on beat 9), out_ready=1 -> out_class=2, out_score=9, out_error=0, one cycle after the last beat.
REQ-035 Ten beats of all -100 with in_last on beat 9 -> out_class=0, out_score=-100, out_error=0.
REQ-036 Three beats 1,7,3 with in_last on beat 2 -> out_class=1, out_score=7, out_error=1.
REQ-037 Ten beats with in_last never asserted -> HOLD after beat 9, out_error=1; with out_ready held low for 5 cycles, outputs stable and in_ready=0 throughout.
REQ-038 GlobalReset pulsed after 4 beats, then a clean 10-beat frame -> only the second frame's result appears, and it is correct.
REQ-039 With NEURON_ARGMAX_BIAS_EN defined, beat 0 in_value=2^25-1, in_bias=10 -> score saturates to 2^25-1; beat 1 in_value=-2^25, in_bias=-1 -> score saturates to -2^25.
